// File: rtl/video_timing_checker.sv
// Sink-side monitor for the GPU video stream: measures line/frame timing, signs each frame, reports lock.
// Define VIDEO_TIMING_CHECKER_CRC_EN for a CRC-32 frame signature instead of a pixel sum.
module video_timing_checker #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned SYNC_POL    = 0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        gpu_clk,
   input  logic        rst,
   input  logic [23:0] pixel,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        vde,
   output logic        frame_valid,
   output logic [11:0] h_active_meas,
   output logic [11:0] h_total_meas,
   output logic [11:0] v_active_meas,
   output logic [11:0] v_total_meas,
   output logic [31:0] frame_sig,
   output logic        mismatch,
   output logic        locked,
   output logic [15:0] frame_count
);

   localparam logic        POL    = (SYNC_POL != 0);
   localparam logic [11:0] CMAX   = '1;
   localparam logic [11:0] EXP_HA = 12'(H_ACTIVE);
   localparam logic [11:0] EXP_HT = 12'(H_TOTAL);
   localparam logic [11:0] EXP_VA = 12'(V_ACTIVE);
   localparam logic [11:0] EXP_VT = 12'(V_TOTAL);
   localparam logic [15:0] LOCK_N = 16'(LOCK_FRAMES);
`ifdef VIDEO_TIMING_CHECKER_CRC_EN
   localparam logic [31:0] SIG_INIT = '1;
`else
   localparam logic [31:0] SIG_INIT = '0;
`endif

   typedef enum logic {IDLE, MEASURE} state_t;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == CMAX) ? v : v + 12'd1;
   endfunction

   function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [23:0] p);
`ifdef VIDEO_TIMING_CHECKER_CRC_EN
      logic [31:0] c;
      logic [23:0] d;
      logic        fb;
      c = s;
      d = p;
      for (int unsigned i = 0; i < 24; i++) begin
         fb = c[31] ^ d[23];
         c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
         d  = {d[22:0], 1'b0};
      end
      return c;
`else
      return s + {8'h00, p};
`endif
   endfunction

   state_t      state;
   logic [23:0] pixel_r;
   logic        hs_r, vs_r, de_r, hs_p, vs_p;
   logic [11:0] h_cnt, de_cnt, v_tot, v_act, line_len, last_act, first_act;
   logic        first_seen, act_bad, sat, h_seen;
   logic [31:0] sig;
   logic [15:0] clean_cnt;
   logic        hs_edge, vs_edge, line_end, line_active, frame_mismatch;

   // Sync inputs are stored as "active" flags so edge logic is polarity-free.
   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         pixel_r <= '0;
         hs_r    <= 1'b0;
         vs_r    <= 1'b0;
         de_r    <= 1'b0;
         hs_p    <= 1'b0;
         vs_p    <= 1'b0;
      end else begin
         pixel_r <= pixel;
         hs_r    <= (hsync == POL);
         vs_r    <= (vsync == POL);
         de_r    <= vde;
         hs_p    <= hs_r;
         vs_p    <= vs_r;
      end
   end

   always_comb begin
      hs_edge        = hs_r & ~hs_p;
      vs_edge        = vs_r & ~vs_p;
      line_end       = hs_edge & ~vs_edge;
      line_active    = (de_cnt != '0);
      frame_mismatch = (last_act != EXP_HA) | (line_len != EXP_HT) |
                       (v_act != EXP_VA) | (v_tot != EXP_VT) | act_bad | sat;
   end

   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         state         <= IDLE;
         h_cnt         <= '0;
         de_cnt        <= '0;
         v_tot         <= '0;
         v_act         <= '0;
         line_len      <= '0;
         last_act      <= '0;
         first_act     <= '0;
         first_seen    <= 1'b0;
         act_bad       <= 1'b0;
         sat           <= 1'b0;
         h_seen        <= 1'b0;
         sig           <= '0;
         clean_cnt     <= '0;
         frame_valid   <= 1'b0;
         h_active_meas <= '0;
         h_total_meas  <= '0;
         v_active_meas <= '0;
         v_total_meas  <= '0;
         frame_sig     <= '0;
         mismatch      <= 1'b0;
         locked        <= 1'b0;
         frame_count   <= '0;
      end else begin
         frame_valid <= 1'b0;
         h_seen      <= h_seen | hs_edge;

         // The hsync edge cycle is the first cycle of the new line.
         if (hs_edge) begin
            h_cnt  <= 12'd1;
            de_cnt <= {11'b0, de_r};
         end else begin
            h_cnt  <= sat_inc(h_cnt);
            de_cnt <= de_r ? sat_inc(de_cnt) : de_cnt;
         end

         case (state)
            IDLE: begin
               if (vs_edge) state <= MEASURE;
            end
            MEASURE: begin
               if (vs_edge) begin
                  frame_valid   <= 1'b1;
                  h_active_meas <= last_act;
                  h_total_meas  <= line_len;
                  v_active_meas <= v_act;
                  v_total_meas  <= v_tot;
                  frame_sig     <= sig;
                  mismatch      <= frame_mismatch;
                  frame_count   <= frame_count + 16'd1;
                  if (frame_mismatch) begin
                     clean_cnt <= '0;
                     locked    <= 1'b0;
                  end else begin
                     if (clean_cnt != '1) clean_cnt <= clean_cnt + 16'd1;
                     if (clean_cnt + 16'd1 >= LOCK_N) locked <= 1'b1;
                  end
               end
            end
         endcase

         // A coincident hsync edge opens the new frame rather than closing the old one.
         if (vs_edge) begin
            v_tot      <= {11'b0, hs_edge};
            v_act      <= '0;
            line_len   <= '0;
            last_act   <= '0;
            first_act  <= '0;
            first_seen <= 1'b0;
            act_bad    <= 1'b0;
            sat        <= 1'b0;
            sig        <= de_r ? sig_step(SIG_INIT, pixel_r) : SIG_INIT;
         end else if (state == MEASURE) begin
            if (de_r) sig <= sig_step(sig, pixel_r);
            if ((!hs_edge && ((h_cnt == CMAX) || (de_r && de_cnt == CMAX))) ||
                (line_end && ((v_tot == CMAX) || (line_active && v_act == CMAX))))
               sat <= 1'b1;
            if (line_end) begin
               v_tot <= sat_inc(v_tot);
               if (h_seen) line_len <= h_cnt;
               if (line_active) begin
                  v_act    <= sat_inc(v_act);
                  last_act <= de_cnt;
                  if (!first_seen) begin
                     first_act  <= de_cnt;
                     first_seen <= 1'b1;
                  end else if (de_cnt != first_act) begin
                     act_bad <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_checker.sv
// Scoreboard bench for video_timing_checker on a small 12x6 timing (8x4 active, active-low syncs).
module tb_video_timing_checker;

   localparam int HA = 8;
   localparam int HT = 12;
   localparam int VA = 4;
   localparam int VT = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] pixel;
   logic        hsync, vsync, vde;
   logic        frame_valid;
   logic [11:0] h_active_meas, h_total_meas, v_active_meas, v_total_meas;
   logic [31:0] frame_sig;
   logic        mismatch, locked;
   logic [15:0] frame_count;

   video_timing_checker #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
      .SYNC_POL(0), .LOCK_FRAMES(2)
   ) dut (
      .gpu_clk(clk), .rst(rst), .pixel(pixel), .hsync(hsync), .vsync(vsync), .vde(vde),
      .frame_valid(frame_valid), .h_active_meas(h_active_meas), .h_total_meas(h_total_meas),
      .v_active_meas(v_active_meas), .v_total_meas(v_total_meas), .frame_sig(frame_sig),
      .mismatch(mismatch), .locked(locked), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] ha, ht, va, vt;
      logic [31:0] sig;
      logic        mis, lk;
      logic [15:0] fc;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          armed, prev_coinc, exp_locked;
   int          exp_clean;
   logic [15:0] exp_fc;

`ifdef VIDEO_TIMING_CHECKER_CRC_EN
   localparam logic [31:0] MODEL_INIT = 32'hFFFFFFFF;
`else
   localparam logic [31:0] MODEL_INIT = 32'h0;
`endif

   function automatic logic [31:0] model_step(input logic [31:0] s, input logic [23:0] p);
`ifdef VIDEO_TIMING_CHECKER_CRC_EN
      logic [31:0] c;
      c = s;
      for (int b = 23; b >= 0; b--) begin
         if (c[31] ^ p[b[4:0]]) c = (c << 1) ^ 32'h04C11DB7;
         else c = c << 1;
      end
      return c;
`else
      return s + 32'(p);
`endif
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame_valid at cycle %0d frame_count=%0d", cyc, frame_count);
         end else begin
            mon_e = q.pop_front();
            if (cyc !== mon_e.cyc) begin
               errors++;
               $display("FAIL fv_latency cycle got %0d want %0d", cyc, mon_e.cyc);
            end
            checks++;
            if (h_active_meas !== mon_e.ha) begin
               errors++;
               $display("FAIL h_active_meas got %0d want %0d", h_active_meas, mon_e.ha);
            end
            checks++;
            if (h_total_meas !== mon_e.ht) begin
               errors++;
               $display("FAIL h_total_meas got %0d want %0d", h_total_meas, mon_e.ht);
            end
            checks++;
            if (v_active_meas !== mon_e.va) begin
               errors++;
               $display("FAIL v_active_meas got %0d want %0d", v_active_meas, mon_e.va);
            end
            checks++;
            if (v_total_meas !== mon_e.vt) begin
               errors++;
               $display("FAIL v_total_meas got %0d want %0d", v_total_meas, mon_e.vt);
            end
            checks++;
            if (frame_sig !== mon_e.sig) begin
               errors++;
               $display("FAIL frame_sig got %08h want %08h", frame_sig, mon_e.sig);
            end
            checks++;
            if (mismatch !== mon_e.mis) begin
               errors++;
               $display("FAIL mismatch got %0b want %0b", mismatch, mon_e.mis);
            end
            checks++;
            if (locked !== mon_e.lk) begin
               errors++;
               $display("FAIL locked got %0b want %0b", locked, mon_e.lk);
            end
            checks++;
            if (frame_count !== mon_e.fc) begin
               errors++;
               $display("FAIL frame_count got %0d want %0d", frame_count, mon_e.fc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      hsync = 1'b1;
      vsync = 1'b1;
      vde   = 1'b0;
      pixel = '0;
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
      armed      = 1'b0;
      prev_coinc = 1'b0;
      exp_clean  = 0;
      exp_locked = 1'b0;
      exp_fc     = '0;
      q.delete();
   endtask

   // One generated frame: lines 0-3 active (vde at cols 3..), lines 4-5 blank, vsync asserts in line 5.
   task automatic run_frame(input bit coinc, input int short_line, input bit long4,
                            input bit vary, input logic [23:0] base, input int nlines);
      int          cnt[4];
      int          len, de_n, vcol, eha, eht, evt;
      logic [31:0] msig;
      logic [23:0] p;
      bit          d, bad;
      exp_t        e;
      msig = MODEL_INIT;
      vcol = coinc ? 0 : 5;
      for (int l = 0; l < nlines; l++) begin
         len  = (long4 && l == 4) ? 13 : 12;
         de_n = (l == short_line) ? 7 : 8;
         if (l < 4) cnt[l] = de_n;
         for (int c = 0; c < len; c++) begin
            d     = (l < 4) && (c >= 3) && (c < 3 + de_n);
            p     = vary ? (base ^ 24'(l * 37 + c * 5)) : base;
            hsync = (c < 2) ? 1'b0 : 1'b1;
            vsync = (l == 5 && c >= vcol) ? 1'b0 : 1'b1;
            vde   = d;
            pixel = d ? p : 24'($urandom);
            if (d) msig = model_step(msig, p);
            if (l == 5 && c == vcol) begin
               if (armed) begin
                  eha = cnt[3];
                  eht = (!coinc && long4) ? 13 : 12;
                  evt = coinc ? (prev_coinc ? 6 : 5) : (prev_coinc ? 7 : 6);
                  bad = 1'b0;
                  for (int i = 1; i < 4; i++) if (cnt[i] != cnt[0]) bad = 1'b1;
                  e.mis = (eha != HA) || (eht != HT) || (VA != 4) || (evt != VT) || bad;
                  if (e.mis) begin
                     exp_clean  = 0;
                     exp_locked = 1'b0;
                  end else begin
                     exp_clean++;
                     if (exp_clean >= 2) exp_locked = 1'b1;
                  end
                  exp_fc = exp_fc + 16'd1;
                  e.ha  = 12'(eha);
                  e.ht  = 12'(eht);
                  e.va  = 12'd4;
                  e.vt  = 12'(evt);
                  e.sig = msig;
                  e.lk  = exp_locked;
                  e.fc  = exp_fc;
                  e.cyc = cyc + 2;
                  q.push_back(e);
               end else begin
                  armed = 1'b1;
               end
               prev_coinc = coinc;
            end
            tick();
         end
      end
   endtask

   task automatic test_reset();
      do_reset(4);
      checks++;
      if ({frame_valid, h_active_meas, h_total_meas, v_active_meas, v_total_meas,
           frame_sig, mismatch, locked, frame_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got fc=%0d sig=%08h lk=%0b want all zero", frame_count, frame_sig, locked);
      end
      idle(30);
      checks++;
      if ({frame_valid, v_total_meas, frame_count, locked} !== '0) begin
         errors++;
         $display("FAIL no_vsync_hold got fc=%0d vt=%0d want 0", frame_count, v_total_meas);
      end
   endtask

   task automatic test_clean_frames();
      repeat (4) run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000001, 6);
      checks++;
      if (frame_count !== 16'd3 || locked !== 1'b1) begin
         errors++;
         $display("FAIL clean_lock got fc=%0d lk=%0b want fc=3 lk=1", frame_count, locked);
      end
`ifndef VIDEO_TIMING_CHECKER_CRC_EN
      checks++;
      if (frame_sig !== 32'h00000020) begin
         errors++;
         $display("FAIL sum_const_one got %08h want 00000020", frame_sig);
      end
`endif
   endtask

   task automatic test_varied_pixels();
      run_frame(1'b0, -1, 1'b0, 1'b1, 24'hA5C3F0, 6);
      run_frame(1'b0, -1, 1'b0, 1'b1, 24'h123456, 6);
   endtask

   task automatic test_short_line();
      run_frame(1'b0, 1, 1'b0, 1'b0, 24'h000001, 6);
      checks++;
      if (mismatch !== 1'b1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL short_line got mis=%0b lk=%0b want mis=1 lk=0", mismatch, locked);
      end
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000001, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000001, 6);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL relock got %0b want 1", locked);
      end
   endtask

   task automatic test_long_line();
      run_frame(1'b0, -1, 1'b1, 1'b1, 24'h00FF00, 6);
      checks++;
      if (h_total_meas !== 12'd13 || mismatch !== 1'b1) begin
         errors++;
         $display("FAIL long_line got ht=%0d mis=%0b want ht=13 mis=1", h_total_meas, mismatch);
      end
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000002, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000002, 6);
   endtask

   task automatic test_midframe_reset();
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000003, 3);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_before_reset got %0d want 0", q.size());
      end
      do_reset(1);
      checks++;
      if ({frame_valid, h_active_meas, h_total_meas, v_active_meas, v_total_meas,
           frame_sig, mismatch, locked, frame_count} !== '0) begin
         errors++;
         $display("FAIL midframe_reset got fc=%0d lk=%0b sig=%08h want all zero", frame_count, locked, frame_sig);
      end
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000003, 6);
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL arm_after_reset got fc=%0d want 0", frame_count);
      end
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000003, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000003, 6);
      checks++;
      if (frame_count !== 16'd2 || locked !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_lock got fc=%0d lk=%0b want fc=2 lk=1", frame_count, locked);
      end
   endtask

   task automatic test_coincident();
      do_reset(4);
      run_frame(1'b1, -1, 1'b0, 1'b0, 24'h000001, 6);
      for (int k = 0; k < 2; k++) begin
         run_frame(1'b1, -1, 1'b0, 1'b1, 24'h0F0F0F, 6);
         checks++;
         if (v_total_meas !== 12'd6) begin
            errors++;
            $display("FAIL coincident_vtotal frame %0d got %0d want 6", k, v_total_meas);
         end
      end
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000001, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000001, 6);
   endtask

   task automatic test_zero_pixels();
      logic [31:0] ref_sig;
      ref_sig = MODEL_INIT;
      for (int i = 0; i < 32; i++) ref_sig = model_step(ref_sig, 24'h0);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000000, 6);
      run_frame(1'b0, -1, 1'b0, 1'b0, 24'h000000, 6);
      checks++;
      if (frame_sig !== ref_sig) begin
         errors++;
         $display("FAIL zero_pixel_sig got %08h want %08h", frame_sig, ref_sig);
      end
`ifdef VIDEO_TIMING_CHECKER_CRC_EN
      checks++;
      if (frame_sig === 32'h0) begin
         errors++;
         $display("FAIL crc_zero_nonzero got %08h want nonzero", frame_sig);
      end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      vde = 1'b0;
      pixel = '0;
      test_reset();
      test_clean_frames();
      test_varied_pixels();
      test_short_line();
      test_long_line();
      test_midframe_reset();
      test_coincident();
      test_zero_pixels();
      idle(10);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_frame_valid got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
